// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master / three-slave bus arbiter:
// grant encodings, slave one-hot selects and the arbiter FSM states.
package bus_arbiter_pkg;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M1   = 2'b01;
    localparam logic [1:0] GRANT_M2   = 2'b10;

    localparam logic [2:0] SLAVE_NONE = 3'b000;
    localparam logic [2:0] SLAVE_1    = 3'b001;
    localparam logic [2:0] SLAVE_2    = 3'b010;
    localparam logic [2:0] SLAVE_3    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_CONNECT = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side handshake and arbiter select outputs, bundled for the arbiter port.
// The masters drive requests and serial addresses; the arbiter drives the mux selects.
interface bus_arbiter_if;

    logic       m1_request;
    logic       m1_master_valid;
    logic       m1_tx_address;
    logic       m1_tx_done;
    logic       m2_request;
    logic       m2_master_valid;
    logic       m2_tx_address;
    logic       m2_tx_done;
    logic [1:0] bus_grant;
    logic [2:0] slave_grant;
    logic       bus_busy;
    logic       addr_err;
    logic       timeout;

    modport master (
        output m1_request, m1_master_valid, m1_tx_address, m1_tx_done,
        output m2_request, m2_master_valid, m2_tx_address, m2_tx_done,
        input  bus_grant, slave_grant, bus_busy, addr_err, timeout
    );

    modport slave (
        input  m1_request, m1_master_valid, m1_tx_address, m1_tx_done,
        input  m2_request, m2_master_valid, m2_tx_address, m2_tx_done,
        output bus_grant, slave_grant, bus_busy, addr_err, timeout
    );

endinterface

// File: rtl/bus_arbiter_addr_decoder.sv
// Serial slave-address capture (MSB first) and code-to-one-hot slave decode.
// done rises the cycle after the last address bit is captured.
module arb_addr_decoder
    import bus_arbiter_pkg::*;
#(
    parameter int SEL_BITS = 2
)
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic       done,
    output logic       code_ok,
    output logic [2:0] slave_sel
);

    localparam int CW = $clog2(SEL_BITS + 1);

    logic [SEL_BITS-1:0] shift_q;
    logic [CW-1:0]       cnt_q;
    logic [31:0]         code_ext;

    assign done = (cnt_q == CW'(SEL_BITS));

    // Extra bits after the code is complete are ignored until the next clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en && !done) begin
            shift_q <= SEL_BITS'({shift_q, bit_in});
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Zero-extend so codes 1 and 2 stay distinct even for narrow SEL_BITS.
    assign code_ext = 32'(shift_q);

    always_comb begin
        slave_sel = SLAVE_NONE;
        code_ok   = 1'b0;
        case (code_ext)
            32'd0: begin
                slave_sel = SLAVE_1;
                code_ok   = 1'b1;
            end
            32'd1: begin
                slave_sel = SLAVE_2;
                code_ok   = 1'b1;
            end
            32'd2: begin
                slave_sel = SLAVE_3;
                code_ok   = 1'b1;
            end
            default: begin
                slave_sel = SLAVE_NONE;
                code_ok   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with serial slave addressing, bounded
// bus hold and a one-cycle turnaround between owners. All outputs registered.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int SEL_BITS = 2,
    parameter int HOLD_MAX = 255
)
(
    input  logic          clk,
    input  logic          rstn,
    bus_arbiter_if.slave  bus
);

    localparam int HW = $clog2(HOLD_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [2:0]    slave_q, slave_d;
    logic          busy_q;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic          owner_m2_q, owner_m2_d;
    logic          last_m2_q;
    logic [HW-1:0] hold_q, hold_inc;
    logic          hold_reach;

    logic          gnt_req, gnt_valid, gnt_addr, gnt_done;
    logic          dec_clear, dec_shift, dec_done, dec_ok;
    logic [2:0]    dec_slave;

    // Only the current owner's handshake is ever looked at.
    assign gnt_req   = owner_m2_q ? bus.m2_request      : bus.m1_request;
    assign gnt_valid = owner_m2_q ? bus.m2_master_valid : bus.m1_master_valid;
    assign gnt_addr  = owner_m2_q ? bus.m2_tx_address   : bus.m1_tx_address;
    assign gnt_done  = owner_m2_q ? bus.m2_tx_done      : bus.m1_tx_done;

    assign hold_inc   = (hold_q == HW'(HOLD_MAX)) ? hold_q : hold_q + HW'(1);
    assign hold_reach = (hold_inc == HW'(HOLD_MAX));

    arb_addr_decoder #(
        .SEL_BITS (SEL_BITS)
    ) u_addr_decoder (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (dec_clear),
        .shift_en  (dec_shift),
        .bit_in    (gnt_addr),
        .done      (dec_done),
        .code_ok   (dec_ok),
        .slave_sel (dec_slave)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        slave_d    = slave_q;
        err_d      = 1'b0;
        tmo_d      = 1'b0;
        owner_m2_d = owner_m2_q;
        dec_clear  = 1'b0;
        dec_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.m1_request || bus.m2_request) begin
                    // On a tie the master not served last wins.
                    owner_m2_d = bus.m2_request && (!bus.m1_request || !last_m2_q);
                    grant_d    = owner_m2_d ? GRANT_M2 : GRANT_M1;
                    slave_d    = SLAVE_NONE;
                    dec_clear  = 1'b1;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                dec_shift = gnt_valid;
                if (!gnt_req) begin
                    state_d = ST_RELEASE;
                end else if (hold_reach) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else if (dec_done) begin
                    if (dec_ok) begin
                        slave_d = dec_slave;
                        state_d = ST_CONNECT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_CONNECT: begin
                // A completed transfer beats a simultaneous timeout.
                if (gnt_done || !gnt_req) begin
                    state_d = ST_RELEASE;
                end else if (hold_reach) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_RELEASE) begin
            grant_d = GRANT_NONE;
            slave_d = SLAVE_NONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_q    <= GRANT_NONE;
            slave_q    <= SLAVE_NONE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            owner_m2_q <= 1'b0;
            last_m2_q  <= 1'b1;
            hold_q     <= '0;
        end else begin
            grant_q    <= grant_d;
            slave_q    <= slave_d;
            busy_q     <= (state_d != ST_IDLE);
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            owner_m2_q <= owner_m2_d;
            if (state_q == ST_RELEASE) begin
                last_m2_q <= owner_m2_q;
            end
            if (dec_clear) begin
                hold_q <= '0;
            end else if ((state_q == ST_ADDR) || (state_q == ST_CONNECT)) begin
                hold_q <= hold_inc;
            end
        end
    end

    assign bus.bus_grant   = grant_q;
    assign bus.slave_grant = slave_q;
    assign bus.bus_busy    = busy_q;
    assign bus.addr_err    = err_q;
    assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each driven cycle queues the expected
// {bus_grant, slave_grant, bus_busy, addr_err, timeout} for after the next edge.
`timescale 1ns/1ps
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int SEL_BITS = 2;
    localparam int HOLD_MAX = 8;

    // master nibble: {request, master_valid, tx_address, tx_done}
    localparam logic [3:0] IDL  = 4'b0000;
    localparam logic [3:0] REQ  = 4'b1000;
    localparam logic [3:0] B0   = 4'b1100;
    localparam logic [3:0] B1   = 4'b1110;
    localparam logic [3:0] GAP  = 4'b1010;
    localparam logic [3:0] DONE = 4'b1001;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    bus_arbiter_if bus ();

    bus_arbiter #(
        .SEL_BITS (SEL_BITS),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %b required %b (grant,slave,busy,err,tmo)", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ev(input logic [1:0] g, input logic [2:0] s,
                                      input logic b, input logic e, input logic t);
        return {g, s, b, e, t};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.bus_grant, bus.slave_grant, bus.bus_busy, bus.addr_err, bus.timeout};
    endfunction

    task automatic drive(input logic [3:0] m1, input logic [3:0] m2);
        {bus.m1_request, bus.m1_master_valid, bus.m1_tx_address, bus.m1_tx_done} = m1;
        {bus.m2_request, bus.m2_master_valid, bus.m2_tx_address, bus.m2_tx_done} = m2;
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 8'(exp_q.size()), 8'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, observed(), e.val);
        end
    endtask

    task automatic step(input logic [3:0] m1, input logic [3:0] m2,
                        input logic [7:0] exp, input string tag);
        exp_t e;
        drive(m1, m2);
        e.tag = tag;
        e.val = exp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic check_now(input logic [7:0] exp, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        exp_q.push_back(e);
        #1;
        pop_check();
    endtask

    task automatic fair_step(input logic own2, input logic [3:0] own, input logic [3:0] oth,
                             input logic [7:0] exp, input string tag);
        if (own2) step(oth, own, exp, tag);
        else      step(own, oth, exp, tag);
    endtask

    task automatic timeout_run(input logic done_at_max, input string pfx);
        logic [3:0] m1;
        logic [7:0] e;
        for (int k = 0; k <= 9; k++) begin
            if (k == 1 || k == 2)                m1 = B0;
            else if (k == 8 && done_at_max)      m1 = DONE;
            else if (k == 9)                     m1 = IDL;
            else                                 m1 = REQ;
            if (k <= 2)      e = ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0);
            else if (k <= 7) e = ev(GRANT_M1, SLAVE_1, 1'b1, 1'b0, 1'b0);
            else if (k == 8) e = ev(GRANT_NONE, SLAVE_NONE, 1'b1, 1'b0, !done_at_max);
            else             e = ev(GRANT_NONE, SLAVE_NONE, 1'b0, 1'b0, 1'b0);
            step(m1, IDL, e, $sformatf("%s_e%0d", pfx, k));
        end
    endtask

    logic [7:0] zero_v;
    logic [7:0] rel_v;

    initial begin
        zero_v = ev(GRANT_NONE, SLAVE_NONE, 1'b0, 1'b0, 1'b0);
        rel_v  = ev(GRANT_NONE, SLAVE_NONE, 1'b1, 1'b0, 1'b0);
        drive(IDL, IDL);
        #2;
        rstn = 1'b0;
        check_now(zero_v, "reset_async");
        step(IDL, IDL, zero_v, "reset_clocked");
        rstn = 1'b1;

        // single request, code 01 -> slave 2
        step(REQ, IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s1_grant");
        step(B0,  IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s1_bit0");
        step(B1,  IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s1_bit1");
        step(REQ, IDL, ev(GRANT_M1, SLAVE_2, 1'b1, 1'b0, 1'b0), "s1_slave");
        step(REQ, IDL, ev(GRANT_M1, SLAVE_2, 1'b1, 1'b0, 1'b0), "s1_hold");
        step(DONE, IDL, rel_v, "s1_release");
        step(IDL, IDL, zero_v, "s1_idle");

        // bad code 11 from master 2
        step(IDL, REQ, ev(GRANT_M2, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s3_grant");
        step(IDL, B1,  ev(GRANT_M2, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s3_bit0");
        step(IDL, B1,  ev(GRANT_M2, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s3_bit1");
        step(IDL, REQ, ev(GRANT_NONE, SLAVE_NONE, 1'b1, 1'b1, 1'b0), "s3_addr_err");
        step(IDL, IDL, zero_v, "s3_idle");

        // hold limit: forced release, then tx_done in the same cycle
        timeout_run(1'b0, "s4_tmo");
        timeout_run(1'b1, "s4_done_wins");

        // address gap of 3 cycles (code 10 -> slave 3), then request dropped
        step(REQ, IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s5_grant");
        step(B1,  IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s5_bit0");
        for (int g = 0; g < 3; g++)
            step(GAP, IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), $sformatf("s5_gap%0d", g));
        step(B0,  IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s5_bit1");
        step(REQ, IDL, ev(GRANT_M1, SLAVE_3, 1'b1, 1'b0, 1'b0), "s5_slave");
        step(IDL, IDL, rel_v, "s5_abort");
        step(IDL, IDL, zero_v, "s5_idle");

        // reset in CONNECT; round-robin memory must come back to master 2
        step(REQ, IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s6_grant");
        step(B0,  IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s6_bit0");
        step(B0,  IDL, ev(GRANT_M1, SLAVE_NONE, 1'b1, 1'b0, 1'b0), "s6_bit1");
        step(REQ, IDL, ev(GRANT_M1, SLAVE_1, 1'b1, 1'b0, 1'b0), "s6_connect");
        drive(REQ, REQ);
        #2;
        rstn = 1'b0;
        check_now(zero_v, "s6_async_rst");
        step(REQ, REQ, zero_v, "s6_rst_held");
        rstn = 1'b1;

        // tie fairness: grants alternate 01, 10, 01
        for (int i = 0; i < 3; i++) begin
            logic       own2;
            logic [1:0] g;
            own2 = (i == 1);
            g    = own2 ? GRANT_M2 : GRANT_M1;
            fair_step(own2, REQ,  REQ,  ev(g, SLAVE_NONE, 1'b1, 1'b0, 1'b0), $sformatf("fair%0d_grant", i));
            fair_step(own2, B0,   REQ,  ev(g, SLAVE_NONE, 1'b1, 1'b0, 1'b0), $sformatf("fair%0d_bit0", i));
            fair_step(own2, B0,   REQ,  ev(g, SLAVE_NONE, 1'b1, 1'b0, 1'b0), $sformatf("fair%0d_bit1", i));
            fair_step(own2, REQ,  REQ,  ev(g, SLAVE_1, 1'b1, 1'b0, 1'b0), $sformatf("fair%0d_slave", i));
            fair_step(own2, REQ,  DONE, ev(g, SLAVE_1, 1'b1, 1'b0, 1'b0), $sformatf("fair%0d_other_done", i));
            fair_step(own2, DONE, REQ,  rel_v, $sformatf("fair%0d_release", i));
            fair_step(own2, REQ,  REQ,  zero_v, $sformatf("fair%0d_turn", i));
        end
        step(IDL, IDL, zero_v, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish by 100us, required finish");
        $fatal(1);
    end

endmodule
